// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline control: opcodes, forward selects,
// sequencer FSM states and the shadow-register records kept per stage.
package core_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_FAULT
    } seq_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       load;
        logic       mem_acc;
    } shadow_e_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_acc;
    } shadow_m_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } shadow_w_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Control bundle between the datapath/decoder and the hazard sequencer.
// master = datapath side, slave = sequencer side.
interface hazard_sequencer_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] RdD;
    logic       RegWriteD;
    logic       ResultSrcD;
    logic       MemWriteD;
    logic       PCSrcE;
    logic       MemReadyM;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       MemErr;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemWriteD, PCSrcE, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, MemErr
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemWriteD, PCSrcE, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, MemErr
    );
endinterface

// File: rtl/hazard_sequencer_forward_sel.sv
// Operand bypass select for one E-stage source register; purely combinational.
// M beats W, and x0 is never forwarded.
module forward_sel
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] sel
);
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush/forward control for the 5-stage core, with E/M/W shadow copies of the
// decode fields. Freezes everything while the M-stage memory access is not ready.
module hazard_sequencer
    import core_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    hazard_sequencer_if.slave   bus
);
    shadow_e_t        sh_e;
    shadow_m_t        sh_m;
    shadow_w_t        sh_w;
    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_err;

    logic       frozen;
    logic       load_use;
    logic       stall_fd;
    logic       stall_em;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Combinational so the very first not-ready cycle already holds every stage.
    assign frozen   = (sh_m.mem_acc && !bus.MemReadyM) || (state == ST_FAULT);
    assign load_use = sh_e.load && (sh_e.rd != 5'd0) &&
                      ((sh_e.rd == bus.Rs1D) || (sh_e.rd == bus.Rs2D));

    always_comb begin
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (frozen) begin
            stall_fd = 1'b1;
            stall_em = 1'b1;
        end else if (bus.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
        end
    end

    forward_sel u_fwd_a (
        .rs          (sh_e.rs1),
        .rd_m        (sh_m.rd),
        .reg_write_m (sh_m.reg_write),
        .rd_w        (sh_w.rd),
        .reg_write_w (sh_w.reg_write),
        .sel         (fwd_a)
    );

    forward_sel u_fwd_b (
        .rs          (sh_e.rs2),
        .rd_m        (sh_m.rd),
        .reg_write_m (sh_m.reg_write),
        .rd_w        (sh_w.rd),
        .reg_write_w (sh_w.reg_write),
        .sel         (fwd_b)
    );

    assign bus.StallF    = stall_fd;
    assign bus.StallD    = stall_fd;
    assign bus.StallE    = stall_em;
    assign bus.StallM    = stall_em;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;
    assign bus.ForwardAE = rst ? FWD_RF : fwd_a;
    assign bus.ForwardBE = rst ? FWD_RF : fwd_b;
    assign bus.MemErr    = mem_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_e     <= '0;
            sh_m     <= '0;
            sh_w     <= '0;
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (!frozen) begin
                sh_w <= '{rd: sh_m.rd, reg_write: sh_m.reg_write};
                sh_m <= '{rd: sh_e.rd, reg_write: sh_e.reg_write, mem_acc: sh_e.mem_acc};
                if (flush_e) begin
                    sh_e <= '0;
                end else begin
                    sh_e <= '{rs1:       bus.Rs1D,
                              rs2:       bus.Rs2D,
                              rd:        bus.RdD,
                              reg_write: bus.RegWriteD,
                              load:      bus.ResultSrcD,
                              mem_acc:   bus.ResultSrcD | bus.MemWriteD};
                end
            end

            case (state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (sh_m.mem_acc && !bus.MemReadyM) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.MemReadyM) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                        state   <= ST_FAULT;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomised and directed checks of hazard_sequencer against a stage-record model
// that tracks instructions per stage and the length of the current not-ready run.
module tb_hazard_sequencer;
    localparam int WAIT_MAX = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_sequencer_if bus ();

    hazard_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        bit         rw;
        bit         ld;
        bit         ma;
    } instr_t;

    instr_t in_e, in_m, in_w;
    int     nr_run;
    bit     faulted;
    int     n_chk = 0;
    int     n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_for(input logic [4:0] rs);
        if (in_m.rw && in_m.rd != 0 && in_m.rd == rs) return 2'b10;
        if (in_w.rw && in_w.rd != 0 && in_w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit frozen_now();
        return (in_m.ma && !bus.MemReadyM) || faulted;
    endfunction

    function automatic bit lu_now();
        return in_e.ld && in_e.rd != 0 && (in_e.rd == bus.Rs1D || in_e.rd == bus.Rs2D);
    endfunction

    task automatic clear_model();
        in_e = '{default: 0};
        in_m = '{default: 0};
        in_w = '{default: 0};
        nr_run = 0;
        faulted = 0;
    endtask

    task automatic set_d(input logic [4:0] rs1, rs2, rd, input bit rw, ld, mw);
        bus.Rs1D = rs1;
        bus.Rs2D = rs2;
        bus.RdD = rd;
        bus.RegWriteD = rw;
        bus.ResultSrcD = ld;
        bus.MemWriteD = mw;
    endtask

    task automatic eval();
        logic sf, sm, fd, fe;
        logic [1:0] fa, fb;
        @(negedge clk);
        sf = 0; sm = 0; fd = 0; fe = 0;
        fa = fwd_for(in_e.rs1);
        fb = fwd_for(in_e.rs2);
        if (rst) begin
            fd = 1; fe = 1; fa = 0; fb = 0;
        end else if (frozen_now()) begin
            sf = 1; sm = 1;
        end else if (bus.PCSrcE) begin
            fd = 1; fe = 1;
        end else if (lu_now()) begin
            sf = 1; fe = 1;
        end
        check("StallF", bus.StallF, sf);
        check("StallD", bus.StallD, sf);
        check("StallE", bus.StallE, sm);
        check("StallM", bus.StallM, sm);
        check("FlushD", bus.FlushD, fd);
        check("FlushE", bus.FlushE, fe);
        check("ForwardAE", bus.ForwardAE, fa);
        check("ForwardBE", bus.ForwardBE, fb);
        check("MemErr", bus.MemErr, faulted);
    endtask

    task automatic adv();
        bit fr, fl;
        @(posedge clk);
        fr = frozen_now();
        fl = !fr && (bus.PCSrcE || lu_now());
        if (rst) begin
            clear_model();
        end else begin
            if (!faulted) begin
                if (in_m.ma && !bus.MemReadyM) begin
                    nr_run++;
                    if (nr_run > WAIT_MAX) faulted = 1;
                end else begin
                    nr_run = 0;
                end
            end
            if (!fr) begin
                in_w = in_m;
                in_m = in_e;
                if (fl) in_e = '{default: 0};
                else in_e = '{rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD, rw: bus.RegWriteD,
                              ld: bus.ResultSrcD, ma: bus.ResultSrcD | bus.MemWriteD};
            end
        end
        #1;
    endtask

    task automatic tick();
        eval();
        adv();
    endtask

    initial begin
        rst = 1;
        bus.PCSrcE = 0;
        bus.MemReadyM = 1;
        set_d(0, 0, 0, 0, 0, 0);
        clear_model();
        @(posedge clk);
        #1;
        eval();
        check("rst_memerr", bus.MemErr, 1'b0);
        check("rst_flushd", bus.FlushD, 1'b1);
        adv();
        rst = 0;

        // load x5 then a consumer of x5
        set_d(0, 0, 5, 1, 1, 0); tick();
        set_d(5, 0, 7, 1, 0, 0);
        eval();
        check("lu_stallf", bus.StallF, 1'b1);
        check("lu_flushe", bus.FlushE, 1'b1);
        adv();
        eval();
        check("lu_once", bus.StallF, 1'b0);
        adv();
        set_d(0, 0, 0, 0, 0, 0);
        eval();
        check("lu_fwd_w", bus.ForwardAE, 2'b01);
        adv();

        // M beats W on the same rd; rd=0 in M falls through to W
        set_d(0, 0, 3, 1, 0, 0); tick();
        set_d(0, 0, 3, 1, 0, 0); tick();
        set_d(0, 3, 4, 1, 0, 0); tick();
        set_d(0, 0, 0, 0, 0, 0);
        eval();
        check("fwd_m_wins", bus.ForwardBE, 2'b10);
        adv();
        set_d(0, 0, 3, 1, 0, 0); tick();
        set_d(0, 0, 0, 1, 0, 0); tick();
        set_d(0, 3, 4, 1, 0, 0); tick();
        set_d(0, 0, 0, 0, 0, 0);
        eval();
        check("fwd_rdm0", bus.ForwardBE, 2'b01);
        adv();

        // branch coincident with load-use
        set_d(0, 0, 5, 1, 1, 0); tick();
        set_d(5, 0, 7, 1, 0, 0);
        bus.PCSrcE = 1;
        eval();
        check("br_flushd", bus.FlushD, 1'b1);
        check("br_flushe", bus.FlushE, 1'b1);
        check("br_stallf", bus.StallF, 1'b0);
        adv();
        bus.PCSrcE = 0;

        // memory wait: 3 not-ready cycles then ready
        set_d(0, 0, 6, 1, 1, 0); tick();
        set_d(6, 0, 8, 1, 0, 0); tick();
        bus.MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            check("wait_stallm", bus.StallM, 1'b1);
            check("wait_flushe", bus.FlushE, 1'b0);
            adv();
        end
        bus.MemReadyM = 1;
        eval();
        check("wait_release", bus.StallM, 1'b0);
        adv();
        set_d(0, 0, 0, 0, 0, 0);
        eval();
        check("wait_fwd", bus.ForwardAE, 2'b01);
        adv();

        // timeout into FAULT, then reset
        set_d(0, 0, 9, 1, 1, 0); tick();
        set_d(0, 0, 0, 0, 0, 0); tick();
        bus.MemReadyM = 0;
        for (int i = 0; i < 17; i++) begin
            eval();
            if (i == 15) check("fault_early", bus.MemErr, 1'b0);
            adv();
        end
        bus.MemReadyM = 1;
        eval();
        check("fault_memerr", bus.MemErr, 1'b1);
        check("fault_frozen", bus.StallM, 1'b1);
        adv();
        rst = 1;
        tick();
        eval();
        check("fault_rst_memerr", bus.MemErr, 1'b0);
        check("fault_rst_stallf", bus.StallF, 1'b0);
        adv();
        rst = 0;
        tick();

        // x0 never forwards or stalls
        set_d(0, 0, 0, 1, 0, 0); tick();
        set_d(0, 0, 2, 1, 0, 0); tick();
        set_d(0, 0, 0, 0, 0, 0);
        eval();
        check("x0_fwd", bus.ForwardAE, 2'b00);
        adv();
        set_d(0, 0, 0, 1, 1, 0); tick();
        set_d(0, 0, 1, 1, 0, 0);
        eval();
        check("x0_no_lu", bus.StallF, 1'b0);
        adv();

        // randomised traffic
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.PCSrcE = ($urandom_range(0, 99) < 15);
            bus.MemReadyM = ($urandom_range(0, 99) < 80);
            set_d(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 4) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
